// File: rtl/imem_fetch_arbiter.sv
// Shares one combinational instruction ROM port between CPU fetch and a debug readback port.
// One access per cycle, byte-to-word translation, range/alignment checks, registered responses.
module imem_fetch_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int ROM_WORDS  = 30,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_instr,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    input  logic              fetch_flush,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_err,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_valid,
    output logic [DATA_W-1:0] dbg_data,
    output logic              dbg_err
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W:0]  ROM_LIMIT  = (ADDR_W + 1)'(ROM_WORDS);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              fetch_err_q, fetch_err_d;
    logic [DATA_W-1:0] fetch_instr_q, fetch_instr_d;
    logic              dbg_valid_q, dbg_valid_d;
    logic              dbg_err_q, dbg_err_d;
    logic [DATA_W-1:0] dbg_data_q, dbg_data_d;

    logic [ADDR_W-1:0] fetch_word;
    logic              fetch_bad;
    logic              dbg_bad;
    logic              fetch_elig;
    logic              dbg_forced;

    always_comb begin
        fetch_word = fetch_addr[ADDR_W+1:2];
        fetch_bad  = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:ADDR_W+2] != '0) ||
                     ({1'b0, fetch_word} >= ROM_LIMIT);
        dbg_bad    = ({1'b0, dbg_addr} >= ROM_LIMIT);
        fetch_elig = fetch_req && !fetch_flush;
        dbg_forced = (starve_q == STARVE_LIM);

        // Grants are held low during reset so nothing is consumed while the responders are cleared.
        dbg_gnt   = rst_n && dbg_req && (!fetch_elig || dbg_forced);
        fetch_gnt = rst_n && fetch_elig && !dbg_gnt;
        rom_addr  = dbg_gnt ? dbg_addr : fetch_word;
    end

    always_comb begin
        starve_d = starve_q;
        if (dbg_gnt || !dbg_req) begin
            starve_d = '0;
        end else if (fetch_gnt && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + CNT_W'(1);
        end

        // Faulting addresses never pass ROM data through, so unpopulated words cannot leak X.
        fetch_valid_d = fetch_gnt;
        fetch_err_d   = fetch_gnt && fetch_bad;
        fetch_instr_d = (fetch_gnt && !fetch_bad) ? rom_instr : '0;
        dbg_valid_d   = dbg_gnt;
        dbg_err_d     = dbg_gnt && dbg_bad;
        dbg_data_d    = (dbg_gnt && !dbg_bad) ? rom_instr : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q      <= '0;
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_instr_q <= '0;
            dbg_valid_q   <= 1'b0;
            dbg_err_q     <= 1'b0;
            dbg_data_q    <= '0;
        end else begin
            starve_q      <= starve_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_err_q   <= fetch_err_d;
            fetch_instr_q <= fetch_instr_d;
            dbg_valid_q   <= dbg_valid_d;
            dbg_err_q     <= dbg_err_d;
            dbg_data_q    <= dbg_data_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_err   = fetch_err_q;
    assign fetch_instr = fetch_instr_q;
    assign dbg_valid   = dbg_valid_q;
    assign dbg_err     = dbg_err_q;
    assign dbg_data    = dbg_data_q;

endmodule
